// File: rtl/des_round_ctrl.sv
// Round sequencer for an iterative single-round DES datapath: handshakes a block in,
// steps the datapath through ROUNDS rounds with per-round key rotation, and handshakes it out.
module des_round_ctrl #(
    parameter  int              ROUNDS    = 16,
    parameter  logic [ROUNDS-1:0] SHIFT_MAP = 16'h7EFC,
    localparam int              RW        = $clog2(ROUNDS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_decrypt,
    output logic          out_valid,
    input  logic          out_ready,
    input  logic          abort,
    output logic          dp_load,
    output logic          dp_round_en,
    output logic [RW-1:0] dp_round_idx,
    output logic [1:0]    dp_key_shift,
    output logic          dp_key_dir,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [RW-1:0] idx, idx_n;
    logic          dir_r;
    logic          accept;

    // Decrypt walks the encrypt schedule backwards as right rotates; its first
    // round needs no rotate because PC1 output is already aligned with K16.
    function automatic logic [1:0] key_shift(input logic dec, input logic [RW-1:0] i);
        logic [RW-1:0] j;
        j = RW'(ROUNDS) - i;
        if (!dec)
            return SHIFT_MAP[i] ? 2'd2 : 2'd1;
        else if (i == '0)
            return 2'd0;
        else
            return SHIFT_MAP[j] ? 2'd2 : 2'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            dir_r <= 1'b0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            if (accept)
                dir_r <= in_decrypt;
        end
    end

    always_comb begin
        state_n     = state;
        idx_n       = idx;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        dp_round_en = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_n = ROUND;
                    idx_n   = '0;
                end
            end
            ROUND: begin
                dp_round_en = 1'b1;
                if (idx == RW'(ROUNDS - 1)) begin
                    state_n = DONE;
                    idx_n   = '0;
                end else begin
                    idx_n = idx + RW'(1);
                end
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                // Consume and reload may share an edge, so back-to-back blocks skip IDLE.
                if (out_ready) begin
                    state_n = in_valid ? ROUND : IDLE;
                    idx_n   = '0;
                end
            end
            default: begin
                state_n = IDLE;
                idx_n   = '0;
            end
        endcase
        if (abort) begin
            state_n  = IDLE;
            idx_n    = '0;
            in_ready = 1'b0;
        end
    end

    assign accept       = in_valid & in_ready;
    assign dp_load      = accept;
    assign dp_round_idx = idx;
    assign dp_key_shift = dp_round_en ? key_shift(dir_r, idx) : 2'd0;
    assign dp_key_dir   = dir_r;
    assign busy         = (state != IDLE);

endmodule
